// File: rtl/axil_pkg.sv
// Shared definitions for the AXI-Lite command master: FSM states and response codes.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [2:0] PROT_NONE   = 3'b000;

endpackage

// File: rtl/axil_master.sv
// Single-outstanding AXI-Lite master: turns one command into one AXI read or write
// and returns one response, aborting with SLVERR if the slave stalls too long.
module axil_master
  import axil_pkg::*;
#(
  parameter int ADDR_W  = 21,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,

  output logic              m_axil_awvalid,
  input  logic              m_axil_awready,
  output logic [ADDR_W-1:0] m_axil_awaddr,
  output logic [2:0]        m_axil_awprot,
  output logic              m_axil_wvalid,
  input  logic              m_axil_wready,
  output logic [31:0]       m_axil_wdata,
  output logic [3:0]        m_axil_wstrb,
  input  logic              m_axil_bvalid,
  output logic              m_axil_bready,
  input  logic [1:0]        m_axil_bresp,

  output logic              m_axil_arvalid,
  input  logic              m_axil_arready,
  output logic [ADDR_W-1:0] m_axil_araddr,
  output logic [2:0]        m_axil_arprot,
  input  logic              m_axil_rvalid,
  output logic              m_axil_rready,
  input  logic [31:0]       m_axil_rdata,
  input  logic [1:0]        m_axil_rresp
);

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  axil_state_e       state_q, state_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]        rsp_resp_q, rsp_resp_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs, waiting;

  assign aw_hs   = awvalid_q & m_axil_awready;
  assign w_hs    = wvalid_q & m_axil_wready;
  assign b_hs    = bready_q & m_axil_bvalid;
  assign ar_hs   = arvalid_q & m_axil_arready;
  assign r_hs    = rready_q & m_axil_rvalid;
  assign any_hs  = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign waiting = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                   (state_q == RD_REQ) || (state_q == RD_DATA);

  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          wstrb_d = cmd_wstrb;
          cnt_d   = '0;
          if (cmd_write) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_REQ;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        // A channel whose valid is already low finished its handshake earlier.
        if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = m_axil_bresp;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end
      end
      RD_REQ: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_hs) begin
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = m_axil_rdata;
          rsp_resp_d    = m_axil_rresp;
          rsp_timeout_d = 1'b0;
          state_d       = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every exit from a waiting state is a handshake, so clearing on handshake
    // also covers state entry; a handshake on the last cycle beats the abort.
    if (waiting) begin
      if (any_hs) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        awvalid_d     = 1'b0;
        wvalid_d      = 1'b0;
        bready_d      = 1'b0;
        arvalid_d     = 1'b0;
        rready_d      = 1'b0;
        rsp_valid_d   = 1'b1;
        rsp_rdata_d   = '0;
        rsp_resp_d    = RESP_SLVERR;
        rsp_timeout_d = 1'b1;
        cnt_d         = '0;
        state_d       = RSP;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready      = (state_q == IDLE);
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign rsp_timeout    = rsp_timeout_q;

  assign m_axil_awvalid = awvalid_q;
  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = PROT_NONE;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = PROT_NONE;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master: a configurable AXI-Lite slave, a response
// scoreboard fed by the stimulus and drained by an independent monitor.
module tb_axil_master;

  localparam int AW = 21;
  localparam int TO = 8;

  logic          clk, rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
  logic [AW-1:0] m_axil_awaddr, m_axil_araddr;
  logic [2:0]    m_axil_awprot, m_axil_arprot;
  logic [31:0]   m_axil_wdata, m_axil_rdata;
  logic [3:0]    m_axil_wstrb;
  logic          m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
  logic          m_axil_rvalid, m_axil_rready;
  logic [1:0]    m_axil_bresp, m_axil_rresp;

  axil_master #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_bresp(m_axil_bresp),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;

  rsp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Slave behaviour: ready/valid fires when its counter equals the delay (-1 = never).
  int aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
  logic [31:0] rdata_val = '0;

  // Monitor statistics (written only by the monitor).
  int aw_beats = 0, w_beats = 0, ar_beats = 0, arv_cycles = 0, wdrop_cycles = 0, rsp_count = 0;
  logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
  logic [31:0]   last_wdata = '0;
  logic [3:0]    last_wstrb = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    int aw_c = 0, w_c = 0, b_c = 0, ar_c = 0, r_c = 0;
    m_axil_awready = 0; m_axil_wready = 0; m_axil_bvalid = 0; m_axil_bresp = 0;
    m_axil_arready = 0; m_axil_rvalid = 0; m_axil_rdata = 0; m_axil_rresp = 0;
    forever begin
      @(posedge clk); #2;
      if (m_axil_awvalid) begin m_axil_awready = (aw_c == aw_delay); aw_c++; end
      else begin m_axil_awready = 0; aw_c = 0; end
      if (m_axil_wvalid) begin m_axil_wready = (w_c == w_delay); w_c++; end
      else begin m_axil_wready = 0; w_c = 0; end
      if (m_axil_bready) begin m_axil_bvalid = (b_c == b_delay); b_c++; end
      else begin m_axil_bvalid = 0; b_c = 0; end
      if (m_axil_arvalid) begin m_axil_arready = (ar_c == ar_delay); ar_c++; end
      else begin m_axil_arready = 0; ar_c = 0; end
      if (m_axil_rready) begin m_axil_rvalid = (r_c == r_delay); r_c++; end
      else begin m_axil_rvalid = 0; r_c = 0; end
      m_axil_bresp = bresp_val;
      m_axil_rresp = rresp_val;
      m_axil_rdata = rdata_val;
    end
  end

  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (m_axil_awvalid && m_axil_awready) begin aw_beats++; last_awaddr = m_axil_awaddr; end
        if (m_axil_wvalid && m_axil_wready) begin
          w_beats++; last_wdata = m_axil_wdata; last_wstrb = m_axil_wstrb;
        end
        if (m_axil_arvalid && m_axil_arready) begin ar_beats++; last_araddr = m_axil_araddr; end
        if (m_axil_arvalid) arv_cycles++;
        if (m_axil_awvalid && !m_axil_wvalid) wdrop_cycles++;
        if (rsp_valid && rsp_ready) begin
          rsp_count++;
          $display("rsp %0d: rdata=%h resp=%b timeout=%b", rsp_count, rsp_rdata, rsp_resp, rsp_timeout);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL rsp_unexpected: got response %0d want none", rsp_count);
          end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
            check("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e.to});
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic [1:0] r, input logic t);
    rsp_t e;
    e.rdata = d; e.resp = r; e.to = t;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    while (!cmd_ready && n < 100) begin step(1); n++; end
    check("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    step(1);
    cmd_valid = 0;
  endtask

  task automatic wait_rsps(input int target);
    int n = 0;
    while (rsp_count < target && n < 100) begin step(1); n++; end
    check("rsp_arrived", rsp_count, target);
  endtask

  initial begin
    int b_aw, b_w, b_ar, b_arv, b_wd, b_rsp;
    rst = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1;
    #3;
    check("rst_awvalid", {31'd0, m_axil_awvalid}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);
    check("awprot", {29'd0, m_axil_awprot}, 32'd0);

    // Write, AW and W accepted in the same cycle, OKAY.
    b_aw = aw_beats; b_w = w_beats; b_wd = wdrop_cycles; b_rsp = rsp_count;
    aw_delay = 0; w_delay = 0; b_delay = 0; bresp_val = 2'b00;
    expect_rsp(32'h0, 2'b00, 1'b0);
    issue(1'b1, 21'h0004, 32'hDEADBEEF, 4'hF);
    wait_rsps(b_rsp + 1);
    check("wr1_aw_beats", aw_beats - b_aw, 1);
    check("wr1_w_beats", w_beats - b_w, 1);
    check("wr1_awaddr", {11'd0, last_awaddr}, 32'h0004);
    check("wr1_wdata", last_wdata, 32'hDEADBEEF);
    check("wr1_wstrb", {28'd0, last_wstrb}, 32'hF);
    check("wr1_no_split", wdrop_cycles - b_wd, 0);

    // Write, W accepted 3 cycles before AW: wvalid drops while awvalid stays.
    b_aw = aw_beats; b_w = w_beats; b_wd = wdrop_cycles; b_rsp = rsp_count;
    aw_delay = 3; w_delay = 0;
    expect_rsp(32'h0, 2'b00, 1'b0);
    issue(1'b1, 21'h0020, 32'h0BADF00D, 4'h3);
    wait_rsps(b_rsp + 1);
    check("wr2_aw_beats", aw_beats - b_aw, 1);
    check("wr2_w_beats", w_beats - b_w, 1);
    check("wr2_w_early_cycles", wdrop_cycles - b_wd, 3);
    check("wr2_wstrb", {28'd0, last_wstrb}, 32'h3);

    // Write, AW before W, slave answers SLVERR.
    b_wd = wdrop_cycles; b_rsp = rsp_count;
    aw_delay = 0; w_delay = 2; bresp_val = 2'b10;
    expect_rsp(32'h0, 2'b10, 1'b0);
    issue(1'b1, 21'h1FFFFC, 32'h01234567, 4'h8);
    wait_rsps(b_rsp + 1);
    check("wr3_no_w_drop", wdrop_cycles - b_wd, 0);
    check("wr3_awaddr", {11'd0, last_awaddr}, 32'h1FFFFC);

    // Read with two data wait cycles.
    b_ar = ar_beats; b_rsp = rsp_count;
    w_delay = 0; bresp_val = 2'b00; ar_delay = 0; r_delay = 2;
    rdata_val = 32'h12345678; rresp_val = 2'b00;
    expect_rsp(32'h12345678, 2'b00, 1'b0);
    issue(1'b0, 21'h0010, 32'hFFFFFFFF, 4'h0);
    wait_rsps(b_rsp + 1);
    check("rd1_ar_beats", ar_beats - b_ar, 1);
    check("rd1_araddr", {11'd0, last_araddr}, 32'h0010);

    // Read with SLVERR data response.
    b_rsp = rsp_count;
    ar_delay = 1; r_delay = 0; rdata_val = 32'hA5A50F0F; rresp_val = 2'b10;
    expect_rsp(32'hA5A50F0F, 2'b10, 1'b0);
    issue(1'b0, 21'h0100, 32'h0, 4'h0);
    wait_rsps(b_rsp + 1);

    // arready never comes: abort after TO cycles of arvalid.
    b_ar = ar_beats; b_arv = arv_cycles; b_rsp = rsp_count;
    ar_delay = -1; rresp_val = 2'b00;
    expect_rsp(32'h0, 2'b10, 1'b1);
    issue(1'b0, 21'h0040, 32'h0, 4'h0);
    wait_rsps(b_rsp + 1);
    check("to_arv_cycles", arv_cycles - b_arv, TO);
    check("to_ar_beats", ar_beats - b_ar, 0);
    check("to_arvalid_low", {31'd0, m_axil_arvalid}, 32'd0);

    // arready on the very last allowed cycle: handshake wins over the abort.
    b_ar = ar_beats; b_arv = arv_cycles; b_rsp = rsp_count;
    ar_delay = TO - 1; r_delay = 0; rdata_val = 32'h55AA55AA;
    expect_rsp(32'h55AA55AA, 2'b00, 1'b0);
    issue(1'b0, 21'h0044, 32'h0, 4'h0);
    wait_rsps(b_rsp + 1);
    check("edge_arv_cycles", arv_cycles - b_arv, TO);
    check("edge_ar_beats", ar_beats - b_ar, 1);

    // bvalid never comes: write abort.
    b_rsp = rsp_count;
    ar_delay = 0; b_delay = -1;
    expect_rsp(32'h0, 2'b10, 1'b1);
    issue(1'b1, 21'h0008, 32'hCCCCCCCC, 4'hF);
    wait_rsps(b_rsp + 1);

    // Response back-pressure for 5 cycles.
    b_delay = 0; rdata_val = 32'hCAFEF00D; rresp_val = 2'b00;
    rsp_ready = 0;
    expect_rsp(32'hCAFEF00D, 2'b00, 1'b0);
    issue(1'b0, 21'h0080, 32'h0, 4'h0);
    begin
      int n = 0;
      while (!rsp_valid && n < 50) begin step(1); n++; end
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
      check("bp_rsp_resp", {30'd0, rsp_resp}, 32'd0);
      check("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      step(1);
    end
    rsp_ready = 1;
    step(1);
    check("bp_idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("bp_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // Reset while waiting for the write response.
    b_rsp = rsp_count;
    b_delay = -1;
    issue(1'b1, 21'h000C, 32'h77777777, 4'hF);
    begin
      int n = 0;
      while (!m_axil_bready && n < 50) begin step(1); n++; end
    end
    check("rst_mid_bready_seen", {31'd0, m_axil_bready}, 32'd1);
    step(1);
    #2 rst = 0;
    #1;
    check("rst_mid_bready", {31'd0, m_axil_bready}, 32'd0);
    check("rst_mid_awvalid", {31'd0, m_axil_awvalid}, 32'd0);
    check("rst_mid_wvalid", {31'd0, m_axil_wvalid}, 32'd0);
    check("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_mid_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_mid_rsp_resp", {30'd0, rsp_resp}, 32'd0);
    check("rst_mid_awaddr", {11'd0, m_axil_awaddr}, 32'd0);
    check("rst_mid_wdata", m_axil_wdata, 32'd0);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    b_delay = 0;
    step(5);
    check("rst_mid_no_rsp", rsp_count - b_rsp, 0);

    // Recovery after reset.
    b_rsp = rsp_count;
    r_delay = 0; rdata_val = 32'h0F1E2D3C; rresp_val = 2'b00;
    expect_rsp(32'h0F1E2D3C, 2'b00, 1'b0);
    issue(1'b0, 21'h0200, 32'h0, 4'h0);
    wait_rsps(b_rsp + 1);

    step(2);
    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axil_master.md
AXIL_MASTER -- requirements
Module: axil_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 21, AXI-Lite address width.
REQ-002 SHALL have parameter TIMEOUT, default 1024, maximum cycles to wait for any single AXI handshake.
REQ-003 SHALL have ports clk (input, 1, sole clock, rising edge) and rst (input, 1, asynchronous active-low reset).
REQ-004 SHALL have command ports: cmd_valid (in, 1); cmd_ready (out, 1); cmd_write (in, 1; 1=write, 0=read); cmd_addr (in, ADDR_W); cmd_wdata (in, 32); cmd_wstrb (in, 4).
REQ-005 SHALL have response ports: rsp_valid (out, 1); rsp_ready (in, 1); rsp_rdata (out, 32); rsp_resp (out, 2); rsp_timeout (out, 1).
REQ-006 SHALL have AXI-Lite write-channel outputs m_axil_awvalid, m_axil_awaddr[ADDR_W], m_axil_awprot[3], m_axil_wvalid, m_axil_wdata[32], m_axil_wstrb[4] and m_axil_bready, plus inputs m_axil_awready, m_axil_wready, m_axil_bvalid and m_axil_bresp[2].
REQ-007 SHALL have AXI-Lite read-channel outputs m_axil_arvalid, m_axil_araddr[ADDR_W], m_axil_arprot[3] and m_axil_rready, plus inputs m_axil_arready, m_axil_rvalid, m_axil_rdata[32] and m_axil_rresp[2].

Function
REQ-008 SHALL implement FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
REQ-009 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&&cmd_ready, SHALL register addr, wdata and wstrb, then enter WR_REQ if cmd_write=1, else RD_REQ.
REQ-010 SHALL, in WR_REQ, assert awvalid and wvalid together from the first cycle of the state.
REQ-011 SHALL deassert awvalid and wvalid independently, each in the cycle after its own handshake; AW and W may complete in either order or in the same cycle.
REQ-012 SHALL move from WR_REQ to WR_RESP once both AW and W handshakes are done, and SHALL assert bready only in WR_RESP.
REQ-013 SHALL, on bvalid&&bready, capture bresp into rsp_resp, set rsp_rdata=0 and rsp_timeout=0, and enter RSP.
REQ-014 SHALL, in RD_REQ, assert arvalid until arready, then enter RD_DATA.
REQ-015 SHALL assert rready only in RD_DATA, and on rvalid SHALL capture rdata into rsp_rdata and rresp into rsp_resp, set rsp_timeout=0, and enter RSP.
REQ-016 SHALL assert rsp_valid only in RSP, holding all rsp_* fields stable, and SHALL return to IDLE in the cycle rsp_valid&&rsp_ready is seen.
REQ-017 SHALL keep AXI address/data outputs stable while their corresponding valid is high.
REQ-018 SHALL drive awprot and arprot constant 3'b000.
REQ-019 SHALL clear a wait counter on every state entry and on every completed handshake, and SHALL increment it each cycle in WR_REQ, WR_RESP, RD_REQ and RD_DATA.
REQ-020 SHALL, when the counter reaches TIMEOUT-1 with no handshake that cycle, deassert all AXI valids/readies next cycle, set rsp_timeout=1, rsp_resp=2'b10 and rsp_rdata=0, and enter RSP; this is an intentional debug abort of a hung slave.
REQ-021 SHALL give a handshake in the same cycle as the timeout boundary priority over the timeout.
REQ-022 SHALL accept exactly one outstanding transaction, with no reordering.

Reset
REQ-023 SHALL, while rst=0, asynchronously force state to IDLE, all AXI valid/ready outputs to 0, rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0, the counter to 0, and all registered addr/data/strb to 0.
REQ-024 SHALL drive cmd_ready=1 in the first cycle after rst deasserts.
REQ-025 SHALL discard any in-flight transaction on reset, with no response issued for it.

Structure
REQ-026 SHALL place the state enum and AXI response constants (OKAY=2'b00, SLVERR=2'b10) in shared package axil_pkg.
REQ-027 SHALL be a single module with no sub-modules; the timeout counter width is $clog2(TIMEOUT+1).

Verification
REQ-028 Write 0x0004/0xDEADBEEF/strb 0xF, slave awready and wready same cycle, bresp=00 -> exactly one AW and one W beat, then rsp_valid with resp=00, timeout=0.
REQ-029 Write with wready 3 cycles before awready -> wvalid drops after its handshake while awvalid stays high; single response with resp=00.
REQ-030 Read 0x0010, slave returns rdata=0x12345678 and rresp=00 after 2 wait cycles -> rsp_rdata=0x12345678 and resp=00.
REQ-031 TIMEOUT=8 with slave never asserting arready -> arvalid high for 8 cycles, then drops; rsp_timeout=1, resp=10, rdata=0.
REQ-032 rsp_ready held low for 5 cycles -> rsp_* stable and cmd_ready=0 throughout; IDLE the cycle after rsp_ready=1.
REQ-033 rst pulled low mid-WR_RESP -> all outputs at reset values immediately, no rsp_valid, cmd_ready=1 the cycle after release.
